// File: rtl/tone_sequencer.sv
// tone_sequencer: note-table driven melody player.
// Steps through stored {pitch, duration} entries and gates the tone path.
module tone_sequencer #(
  parameter int PITCH_BITWIDTH = 9,
  parameter int DUR_BITWIDTH   = 13,
  parameter int IDX_BITWIDTH   = 5,
  parameter int GAP_SAMPLES    = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fs_tick,
  input  logic                      wr_en,
  input  logic [IDX_BITWIDTH-1:0]   wr_addr,
  input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
  input  logic [DUR_BITWIDTH-1:0]   wr_dur,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [IDX_BITWIDTH-1:0]   last_idx,
  output logic [PITCH_BITWIDTH-1:0] pitch,
  output logic                      gate,
  output logic                      tone_restart,
  output logic [IDX_BITWIDTH-1:0]   note_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int DEPTH   = 1 << IDX_BITWIDTH;
  localparam int ENTRY_W = PITCH_BITWIDTH + DUR_BITWIDTH;
  localparam int DW1     = DUR_BITWIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [DW1-1:0] GAP_W = DW1'(GAP_SAMPLES);
  localparam logic [DUR_BITWIDTH-1:0] ONE = DUR_BITWIDTH'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [1:0]                state;
  logic [IDX_BITWIDTH-1:0]   idx;
  logic [IDX_BITWIDTH-1:0]   last_q;
  logic [DUR_BITWIDTH-1:0]   cnt;
  logic [PITCH_BITWIDTH-1:0] cur_pitch;
  logic [DUR_BITWIDTH-1:0]   cur_dur;
  logic [DUR_BITWIDTH-1:0]   cur_play;
  logic                      cur_has_gap;
  logic                      restart_q;
  logic                      done_q;

  logic [ENTRY_W-1:0]        rd_entry;
  logic [PITCH_BITWIDTH-1:0] rd_pitch;
  logic [DUR_BITWIDTH-1:0]   rd_dur;
  logic [DUR_BITWIDTH-1:0]   rd_eff;
  logic [DUR_BITWIDTH-1:0]   rd_play;
  logic                      rd_has_gap;

  logic [DUR_BITWIDTH-1:0]   cnt_nx;
  logic                      note_end;
  logic                      play_end;
  logic                      at_last;

  // Table writes are unconditional on state and reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_pitch, wr_dur};
  end

  always_comb begin
    rd_entry   = mem[idx];
    rd_pitch   = rd_entry[ENTRY_W-1 -: PITCH_BITWIDTH];
    rd_dur     = rd_entry[DUR_BITWIDTH-1:0];
    rd_eff     = (rd_dur == '0) ? ONE : rd_dur;
    rd_has_gap = {1'b0, rd_eff} > GAP_W;
    rd_play    = rd_has_gap ? (rd_eff - GAP_W[DUR_BITWIDTH-1:0]) : rd_eff;
  end

  assign cnt_nx   = cnt + ONE;
  assign note_end = fs_tick && (cnt_nx == cur_dur);
  assign play_end = fs_tick && cur_has_gap && (cnt_nx == cur_play);
  assign at_last  = (idx == last_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      last_q      <= '0;
      cnt         <= '0;
      cur_pitch   <= '0;
      cur_dur     <= ONE;
      cur_play    <= ONE;
      cur_has_gap <= 1'b0;
      restart_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      if (stop) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state  <= LOAD;
              idx    <= '0;
              last_q <= last_idx;
            end
          end
          LOAD: begin
            // Registered table read; any tick here is deliberately lost.
            state       <= PLAY;
            cnt         <= '0;
            cur_pitch   <= rd_pitch;
            cur_dur     <= rd_eff;
            cur_play    <= rd_play;
            cur_has_gap <= rd_has_gap;
            restart_q   <= 1'b1;
          end
          PLAY, GAP: begin
            if (fs_tick) begin
              cnt <= cnt_nx;
              if (note_end) begin
                if (!at_last) begin
                  idx   <= idx + 1'b1;
                  state <= LOAD;
                end else if (loop_en) begin
                  idx   <= '0;
                  state <= LOAD;
                end else begin
                  idx    <= '0;
                  state  <= IDLE;
                  done_q <= 1'b1;
                end
              end else if (play_end) begin
                state <= GAP;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy         = (state != IDLE);
  assign pitch        = (state == PLAY || state == GAP) ? cur_pitch : '0;
  assign gate         = (state == PLAY) && (cur_pitch != '0);
  assign tone_restart = restart_q;
  assign done         = done_q;
  assign note_idx     = idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed bench for tone_sequencer.
// A note-level model is compared on every cycle, plus literal timing checks.
module tb_tone_sequencer;

  localparam int PW  = 9;
  localparam int DW  = 13;
  localparam int IW  = 5;
  localparam int GAP = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          fs_tick = 1'b0;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [PW-1:0] wr_pitch;
  logic [DW-1:0] wr_dur;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [IW-1:0] last_idx;
  logic [PW-1:0] pitch;
  logic          gate;
  logic          tone_restart;
  logic [IW-1:0] note_idx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  tone_sequencer #(
    .PITCH_BITWIDTH(PW),
    .DUR_BITWIDTH(DW),
    .IDX_BITWIDTH(IW),
    .GAP_SAMPLES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fs_tick(fs_tick),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_pitch(wr_pitch),
    .wr_dur(wr_dur),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .last_idx(last_idx),
    .pitch(pitch),
    .gate(gate),
    .tone_restart(tone_restart),
    .note_idx(note_idx),
    .busy(busy),
    .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit chk_en = 0;
  int tick_mode = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 60)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // fs_tick: off, every cycle, or random (about one cycle in three)
  always @(negedge clk) begin
    case (tick_mode)
      0: fs_tick = 1'b0;
      1: fs_tick = 1'b1;
      default: fs_tick = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Note-level model: which note is sounding and how many samples elapsed.
  int m_p [32];
  int m_d [32];
  bit m_active, m_load, m_restart, m_done;
  int m_idx, m_last, m_pitch, m_dur, m_ticks;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 0; m_load = 0; m_restart = 0; m_done = 0;
      m_idx = 0; m_last = 0; m_ticks = 0; m_pitch = 0; m_dur = 1;
    end else begin
      m_restart = 0;
      m_done = 0;
      if (stop) begin
        m_active = 0; m_load = 0; m_idx = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_load = 1; m_idx = 0; m_last = int'(last_idx);
        end
      end else if (m_load) begin
        m_load = 0;
        m_pitch = m_p[m_idx];
        m_dur = (m_d[m_idx] == 0) ? 1 : m_d[m_idx];
        m_ticks = 0;
        m_restart = 1;
      end else if (fs_tick) begin
        m_ticks++;
        if (m_ticks == m_dur) begin
          if (m_idx != m_last) begin
            m_idx = (m_idx + 1) % 32; m_load = 1;
          end else if (loop_en) begin
            m_idx = 0; m_load = 1;
          end else begin
            m_active = 0; m_idx = 0; m_done = 1;
          end
        end
      end
    end
    if (wr_en) begin
      m_p[wr_addr] = int'(wr_pitch);
      m_d[wr_addr] = int'(wr_dur);
    end
  end

  bit sounding;
  int audible;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      sounding = m_active && !m_load;
      audible = (m_dur > GAP) ? (m_dur - GAP) : m_dur;
      check("busy", int'(busy), int'(m_active));
      check("pitch", int'(pitch), sounding ? m_pitch : 0);
      check("gate", int'(gate),
            int'(sounding && m_pitch != 0 && m_ticks < audible));
      check("tone_restart", int'(tone_restart), int'(m_restart));
      check("done", int'(done), int'(m_done));
      check("note_idx", int'(note_idx), m_idx);
      check("gate_while_silent", int'(gate && pitch == 0), 0);
    end
  end

  task automatic write_entry(input int a, input int p, input int d);
    wr_en = 1; wr_addr = IW'(a); wr_pitch = PW'(p); wr_dur = DW'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1;
    @(negedge clk);
    stop = 0;
  endtask

  task automatic wait_restart(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tone_restart && n < 2000);
    check({nm, " restart"}, int'(tone_restart), 1);
  endtask

  // Called on a restart cycle; runs to the next restart or done.
  task automatic measure_note(input string nm, input int ep, input int ei,
                              input int eh, input int eper, input int poke);
    int high;
    int per;
    high = 0;
    per = 0;
    check({nm, " pitch"}, int'(pitch), ep);
    check({nm, " idx"}, int'(note_idx), ei);
    do begin
      if (gate) high++;
      per++;
      start = (poke != 0 && per == poke);
      @(negedge clk);
    end while (!tone_restart && !done && per < 10000);
    start = 0;
    check({nm, " gate cycles"}, high, eh);
    check({nm, " period"}, per, eper);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    reset = 0; wr_en = 0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
    start = 0; stop = 0; loop_en = 0; last_idx = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    write_entry(0, 177, 400);
    write_entry(1, 199, 400);
    check("reset busy", int'(busy), 0);
    check("reset pitch", int'(pitch), 0);
    check("reset note_idx", int'(note_idx), 0);
    reset = 1;
    @(negedge clk);

    // V1
    tick_mode = 1; last_idx = 1; loop_en = 0;
    pulse_start();
    wait_restart("v1", n);
    check("v1 latency", n, 1);
    measure_note("v1 n0", 177, 0, 200, 401, 0);
    measure_note("v1 n1", 199, 1, 200, 400, 0);
    check("v1 done", int'(done), 1);
    check("v1 busy at done", int'(busy), 0);
    @(negedge clk);

    // V2
    d0 = done_cnt;
    loop_en = 1;
    pulse_start();
    wait_restart("v2", n);
    measure_note("v2 n0", 177, 0, 200, 401, 0);
    measure_note("v2 n1", 199, 1, 200, 401, 0);
    check("v2 loop pitch", int'(pitch), 177);
    check("v2 loop idx", int'(note_idx), 0);
    repeat (50) @(negedge clk);
    pulse_stop();
    check("v2 stop gate", int'(gate), 0);
    check("v2 stop pitch", int'(pitch), 0);
    check("v2 stop busy", int'(busy), 0);
    @(negedge clk);
    check("v2 no done", done_cnt - d0, 0);

    // V3
    loop_en = 0; last_idx = 4;
    write_entry(0, 177, 250);
    write_entry(1, 0, 300);
    write_entry(2, 133, 100);
    write_entry(3, 149, 0);
    write_entry(4, 199, 220);
    pulse_start();
    wait_restart("v3", n);
    measure_note("v3 n0", 177, 0, 50, 251, 0);
    measure_note("v3 rest", 0, 1, 0, 301, 0);
    measure_note("v3 short", 133, 2, 100, 101, 0);
    measure_note("v3 zero", 149, 3, 1, 2, 0);
    measure_note("v3 last", 199, 4, 20, 220, 0);
    check("v3 done", int'(done), 1);
    @(negedge clk);

    // V4
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    check("v4 start+stop idle", int'(busy), 0);
    @(negedge clk);
    check("v4 still idle", int'(busy), 0);
    pulse_start();
    wait_restart("v4", n);
    measure_note("v4 n0", 177, 0, 50, 251, 30);
    check("v4 next idx", int'(note_idx), 1);
    pulse_stop();

    // V5
    write_entry(0, 177, 30);
    write_entry(1, 199, 30);
    loop_en = 1; last_idx = 1;
    pulse_start();
    wait_restart("v5", n);
    repeat (10) @(negedge clk);
    write_entry(0, 155, 30);
    check("v5 current unchanged", int'(pitch), 177);
    wait_restart("v5 n1", n);
    check("v5 n1 pitch", int'(pitch), 199);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && pitch == 0) && n < 2000);
    check("v5 load idx", int'(note_idx), 0);
    write_entry(0, 166, 30);
    check("v5 rdw restart", int'(tone_restart), 1);
    measure_note("v5 n0", 155, 0, 30, 31, 0);
    measure_note("v5 n1", 199, 1, 30, 31, 0);
    check("v5 next pass pitch", int'(pitch), 166);
    pulse_stop();

    // V6
    loop_en = 0;
    pulse_start();
    wait_restart("v6", n);
    repeat (5) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("v6 gate", int'(gate), 0);
    check("v6 pitch", int'(pitch), 0);
    check("v6 busy", int'(busy), 0);
    check("v6 restart", int'(tone_restart), 0);
    check("v6 done", int'(done), 0);
    check("v6 idx", int'(note_idx), 0);
    reset = 1;
    @(negedge clk);
    pulse_start();
    wait_restart("v6 replay", n);
    measure_note("v6 n0", 166, 0, 30, 31, 0);
    measure_note("v6 n1", 199, 1, 30, 30, 0);
    check("v6 final done", int'(done), 1);
    @(negedge clk);

    // V7: full table, random sample strobe
    for (int i = 0; i < 32; i++) write_entry(i, i + 1, i % 3);
    last_idx = 31; loop_en = 0; tick_mode = 2;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 5000);
    check("v7 done", int'(done), 1);
    tick_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter PITCH_BITWIDTH, default 9: width of pitch word, the divider maxval for the tone clock generator.
REQ-002 Parameter DUR_BITWIDTH, default 13: width of note duration, in fs samples.
REQ-003 Parameter IDX_BITWIDTH, default 5: note-table address width; the table depth is 2^IDX_BITWIDTH entries.
REQ-004 Parameter GAP_SAMPLES, default 200: articulation gap, in fs samples, with gate low at the end of each note.
REQ-005 clk  in  1  single system clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 fs_tick  in  1  sample-rate strobe, one clk wide.
REQ-008 wr_en  in  1  note-table write strobe.
REQ-009 wr_addr  in  IDX_BITWIDTH  note-table write address.
REQ-010 wr_pitch  in  PITCH_BITWIDTH  pitch to store; 0 = rest.
REQ-011 wr_dur  in  DUR_BITWIDTH  duration to store, in samples.
REQ-012 start  in  1  one-cycle request to begin playback at index 0.
REQ-013 stop  in  1  one-cycle request to abort playback.
REQ-014 loop_en  in  1  restart at index 0 after the last note.
REQ-015 last_idx  in  IDX_BITWIDTH  index of the final note in the melody.
REQ-016 pitch  out  PITCH_BITWIDTH  maxval for the tone clkgen; 0 = silent.
REQ-017 gate  out  1  tone audible; gates the sine/DAC path.
REQ-018 tone_restart  out  1  one-cycle pulse when a new pitch is applied; used to resynchronise the tone clkgen.
REQ-019 note_idx  out  IDX_BITWIDTH  index of the note currently sounding.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 done  out  1  one-cycle pulse when a non-looping melody completes.

Function
REQ-022 The FSM SHALL have four states: IDLE, LOAD, PLAY, GAP.
REQ-023 The note table SHALL be a 2^IDX_BITWIDTH x (PITCH_BITWIDTH+DUR_BITWIDTH) array, written when wr_en is high at wr_addr in any state, with a registered read.
REQ-024 In a read-during-write to the same address in LOAD, the read SHALL return the old entry; the new entry applies the next time that index is loaded.
REQ-025 IDLE: gate=0, pitch=0, busy=0; start -> LOAD with idx=0, and last_idx is latched at that cycle.
REQ-026 LOAD lasts exactly one clk; it reads table[idx] and clears the sample counter.
REQ-027 Latency: start sampled in cycle N -> LOAD in N+1 -> PLAY in N+2, with pitch, gate, note_idx and tone_restart valid in N+2.
REQ-028 On entry to PLAY, tone_restart SHALL pulse for one clk, including when the pitch is unchanged from the previous note.
REQ-029 Duration 0 SHALL be treated as 1 sample.
REQ-030 Let D be the effective duration. The sample counter increments only on fs_tick in PLAY or GAP; an fs_tick during LOAD is dropped.
REQ-031 If D > GAP_SAMPLES: gate=1 while the counter < D-GAP_SAMPLES (PLAY), then gate=0 in GAP until the counter reaches D, with pitch held.
REQ-032 If D <= GAP_SAMPLES: there is no GAP; gate=1 for all D samples.
REQ-033 Rest entry (pitch 0): pitch=0 and gate=0 for all D samples; timing is otherwise identical.
REQ-034 Note end (the fs_tick that brings the counter to D):
  - idx != latched last_idx -> idx+1, go to LOAD;
  - idx == last_idx and loop_en=1 -> idx=0, go to LOAD;
  - otherwise -> IDLE with a done pulse in the same cycle that IDLE is entered.
REQ-035 loop_en SHALL be sampled only at the end of the last note.
REQ-036 The index SHALL wrap modulo 2^IDX_BITWIDTH; last_idx = 2^IDX_BITWIDTH-1 plays the full table.
REQ-037 stop in any state -> IDLE on the next clk, with gate=0 and pitch=0, and no done pulse.
REQ-038 If stop and start are asserted in the same cycle, stop SHALL win.
REQ-039 start while busy SHALL be ignored.
REQ-040 gate SHALL never be 1 while pitch=0.

Reset
REQ-041 While reset=0 at posedge clk, the block SHALL be in IDLE with:
  - pitch=0, gate=0, tone_restart=0, note_idx=0, busy=0, done=0;
  - sample counter=0, latched last_idx=0.
REQ-042 Table contents SHALL NOT be cleared by reset; writes are accepted during reset.
REQ-043 Reset asserted mid-note SHALL force gate low on the next clk, with no done pulse.

Verification
REQ-044 The bench SHALL cover the following scenarios:
  - V1: write {177,400},{199,400}; last_idx=1, loop_en=0; start -> gate high for 200 fs ticks, low for 200, then pitch 199 with a tone_restart pulse; done pulses after 800 ticks; busy drops in the same cycle.
  - V2: same table with loop_en=1 -> after note 1, note_idx=0 and pitch=177 again; stop -> gate=0 and pitch=0 next clk; done never pulses.
  - V3: entry {0,300} between two notes -> gate stays 0 for 300 ticks with pitch=0; entry {133,100} (D <= GAP) -> gate high all 100 ticks; entry {149,0} -> lasts 1 tick.
  - V4: start and stop in the same cycle -> remains IDLE; start while busy -> no effect on note_idx or the counter.
  - V5: write index 0 while it is playing -> the current note is unchanged, and the next loop pass uses the new pitch; an fs_tick coincident with LOAD is not counted.
  - V6: reset=0 mid-note -> all outputs at reset values next clk; table retained, so a subsequent start replays the old contents.
